// File: rtl/timer_down_pkg.sv
// Shared types and defaults for the down-counting interval timer.
package timer_down_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  localparam int WIDTH_D = 8;

endpackage

// File: rtl/timer_down_counter.sv
// Loadable decrementing counter used as the timer datapath.
// Loading has priority over decrementing, and the count stops at zero.
module counter_down
  import timer_down_pkg::*;
#(
  parameter int WIDTH_P = WIDTH_D
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [WIDTH_P-1:0] value_i,
  input  logic               en_i,
  output logic [WIDTH_P-1:0] count_o,
  output logic               term_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (load_i) begin
      count_o <= value_i;
    end else if (en_i && (count_o != '0)) begin
      count_o <= count_o - WIDTH_P'(1);
    end
  end

  assign term_o = (count_o == WIDTH_P'(1));

endmodule

// File: rtl/timer_down.sv
// Interval timer for DDR controller waits: one-shot or periodic expiry with a
// registered single-cycle done pulse. Cancel and load both reuse the counter load path.
module timer_down
  import timer_down_pkg::*;
#(
  parameter int WIDTH_P = WIDTH_D
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [WIDTH_P-1:0] value_i,
  input  logic               periodic_i,
  input  logic               hold_i,
  input  logic               cancel_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH_P-1:0] count_o
);

  state_e             state_q, state_d;
  logic               done_q, done_d;
  logic [WIDTH_P-1:0] reload_q, reload_d;
  logic               periodic_q, periodic_d;
  logic               cnt_load, cnt_en, cnt_term;
  logic [WIDTH_P-1:0] cnt_value;

  counter_down #(.WIDTH_P(WIDTH_P)) u_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (cnt_load),
    .value_i (cnt_value),
    .en_i    (cnt_en),
    .count_o (count_o),
    .term_o  (cnt_term)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
    end
  end

  // Priority cancel > load > hold > decrement; a load on the terminal edge suppresses done.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_value  = value_i;
    if (cancel_i) begin
      state_d   = IDLE;
      cnt_load  = 1'b1;
      cnt_value = '0;
    end else if (load_i) begin
      cnt_load = 1'b1;
      if (value_i != '0) begin
        state_d    = RUN;
        reload_d   = value_i;
        periodic_d = periodic_i;
      end else begin
        state_d   = IDLE;
        cnt_value = '0;
        done_d    = 1'b1;
      end
    end else if ((state_q == RUN) && !hold_i) begin
      if (cnt_term) begin
        done_d = 1'b1;
        if (periodic_q) begin
          cnt_load  = 1'b1;
          cnt_value = reload_q;
        end else begin
          cnt_en  = 1'b1;
          state_d = IDLE;
        end
      end else begin
        cnt_en = 1'b1;
      end
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = done_q;

endmodule

// File: tb/tb_timer_down.sv
// Scoreboard bench for timer_down: a behavioural model predicts each cycle's outputs,
// a separate monitor compares them against the DUT after every rising edge.
module tb_timer_down;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] value = '0;
  logic         periodic = 1'b0;
  logic         hold = 1'b0;
  logic         cancel = 1'b0;
  logic         busy, done;
  logic [W-1:0] count;

  typedef struct {
    logic         busy;
    logic         done;
    logic [W-1:0] count;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int  m_count = 0;
  int  m_reload = 0;
  bit  m_periodic = 0;
  bit  m_running = 0;
  bit  m_done = 0;

  timer_down #(.WIDTH_P(W)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (load),
    .value_i    (value),
    .periodic_i (periodic),
    .hold_i     (hold),
    .cancel_i   (cancel),
    .busy_o     (busy),
    .done_o     (done),
    .count_o    (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour of one clock edge, written directly from the timer rules.
  task automatic modelEdge(input bit r, input bit l, input int v, input bit p, input bit h, input bit c);
    if (r) begin
      m_running = 0; m_count = 0; m_done = 0; m_reload = 0; m_periodic = 0;
      return;
    end
    m_done = 0;
    if (c) begin
      m_running = 0; m_count = 0;
    end else if (l) begin
      if (v != 0) begin
        m_count = v; m_reload = v; m_periodic = p; m_running = 1;
      end else begin
        m_running = 0; m_count = 0; m_done = 1;
      end
    end else if (m_running && !h) begin
      if (m_count == 1) begin
        m_done = 1;
        if (m_periodic) m_count = m_reload;
        else begin m_count = 0; m_running = 0; end
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input bit r, input bit l, input int v,
                               input bit p, input bit h, input bit c);
    exp_t e;
    reset = r; load = l; value = W'(v); periodic = p; hold = h; cancel = c;
    modelEdge(r, l, v, p, h, c);
    e.busy = m_running; e.done = m_done; e.count = W'(m_count); e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic holdFor(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 0, 0, 0, 0, 1, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput({e.tag, ".busy"}, busy, e.busy);
      checkOutput({e.tag, ".done"}, done, e.done);
      checkOutput({e.tag, ".count"}, count, e.count);
    end
  end

  initial begin
    @(negedge clk);
    applyStimulus("reset", 1, 0, 0, 0, 0, 0);
    applyStimulus("reset", 1, 0, 0, 0, 0, 0);

    applyStimulus("oneshot", 0, 1, 5, 0, 0, 0);
    idle("oneshot", 7);

    applyStimulus("periodic", 0, 1, 3, 1, 0, 0);
    idle("periodic", 13);
    applyStimulus("periodic_cancel", 0, 0, 0, 0, 0, 1);
    idle("periodic_cancel", 5);

    applyStimulus("hold", 0, 1, 4, 0, 0, 0);
    idle("hold", 2);
    holdFor("hold", 3);
    idle("hold", 4);

    applyStimulus("hold_term", 0, 1, 3, 0, 0, 0);
    idle("hold_term", 2);
    holdFor("hold_term", 2);
    idle("hold_term", 3);

    applyStimulus("retrigger", 0, 1, 4, 0, 0, 0);
    idle("retrigger", 2);
    applyStimulus("retrigger", 0, 1, 6, 0, 0, 0);
    idle("retrigger", 8);

    applyStimulus("collision", 0, 1, 3, 0, 0, 0);
    idle("collision", 2);
    applyStimulus("collision", 0, 1, 2, 0, 0, 0);
    idle("collision", 4);

    applyStimulus("zero", 0, 1, 0, 1, 0, 0);
    idle("zero", 2);

    applyStimulus("max", 0, 1, 255, 0, 0, 0);
    idle("max", 257);

    applyStimulus("reset_mid", 0, 1, 5, 0, 0, 0);
    idle("reset_mid", 2);
    applyStimulus("reset_mid", 1, 0, 0, 0, 0, 0);
    idle("reset_mid", 2);

    applyStimulus("cancel_load", 0, 1, 5, 0, 0, 1);
    idle("cancel_load", 2);

    applyStimulus("n1_periodic", 0, 1, 1, 1, 0, 0);
    idle("n1_periodic", 5);
    applyStimulus("n1_periodic", 0, 0, 0, 0, 0, 1);
    idle("n1_periodic", 2);

    for (int i = 0; i < 3000; i++) begin
      bit r, l, p, h, c;
      int v;
      r = ($urandom_range(63) == 0);
      c = ($urandom_range(31) == 0);
      l = ($urandom_range(7) == 0);
      p = $urandom_range(1);
      h = ($urandom_range(3) == 0);
      v = ($urandom_range(15) == 0) ? 255 - $urandom_range(2) : $urandom_range(10);
      applyStimulus("random", r, l, v, p, h, c);
    end

    @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_down.md
Name: timer_down

Overview:
- Loadable down-counting interval timer; the decrementing counterpart of the team's up counter.
- Provides DDR controller timing intervals: one-shot waits (tRCD, tRP, tRFC) and periodic refresh ticks (tREFI).
- Controller FSM loads a cycle count, waits on busy_o, and acts on the single-cycle done_o pulse.

Parameters:
WIDTH_P, 8, width of count, load value and reload register; legal range 2..32.

Ports:
clk_i  input  1  single clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
load_i  input  1  load value_i and start (or restart) the timer
value_i  input  WIDTH_P  interval in cycles; sampled only when load_i=1
periodic_i  input  1  sampled with load_i; 1 = auto-reload on expiry, 0 = one-shot
hold_i  input  1  freeze count while high (RUN only)
cancel_i  input  1  abort timer, no done pulse
busy_o  output  1  high while in RUN
done_o  output  1  registered single-cycle expiry pulse
count_o  output  WIDTH_P  current remaining count (registered)

Behaviour:
- Reset is synchronous, active-high: state=IDLE, count_o=0, busy_o=0, done_o=0, reload_r=0, periodic_r=0.
- States:
  - IDLE (busy_o=0).
  - RUN (busy_o=1).
- Per-edge priority: reset_i > cancel_i > load_i > hold_i > decrement.
- done_o defaults to 0 every edge. It is 1 only for the edge cases listed below.
- cancel_i=1 (either state) → IDLE, count_o=0, done_o=0. The reload and periodic registers are retained but unused.
- load_i=1, value_i=N≥1 (either state, retrigger allowed):
  - count_o=N, reload_r=N, periodic_r=periodic_i, state RUN.
  - done_o=0, even if the old count was expiring on that same edge.
- load_i=1, value_i=0:
  - State IDLE, count_o=0, done_o=1 on that edge (one-cycle latency).
  - periodic_i is ignored.
- RUN, hold_i=1: count_o, state and done_o unchanged (done_o=0). Hold on the terminal edge postpones expiry.
- RUN, hold_i=0, count_o>1: count_o decrements by 1.
- RUN, hold_i=0, count_o==1 (terminal edge), done_o=1, and:
  - periodic_r=0: count_o=0, state IDLE.
  - periodic_r=1: count_o=reload_r, state stays RUN.
- Latency: a load of N≥1 at edge k with no hold/cancel gives done_o high in the cycle after edge k+N.
  - Periodic mode then repeats every N cycles; N=1 gives done_o high every cycle.
- IDLE: hold_i ignored, count_o holds 0.
- count_o never wraps below 0; value_i=2^WIDTH_P−1 is legal (maximum interval).
- Reset mid-RUN: immediate IDLE, no done pulse.

Decomposition:
- Package timer_down_pkg:
  - typedef enum logic {IDLE, RUN} state_e.
  - localparam defaults for WIDTH_P.
- Sub-module counter_down: loadable decrementing counter.
  - Ports: clk_i, reset_i, load_i, value_i, en_i, count_o, term_o.
  - term_o is combinational (count==1).
  - Instantiated once. The timer FSM drives load_i/en_i and handles the reload and done logic.

Test Plan:
- Reset → one-shot: reset 2 cycles, then load value_i=5, periodic_i=0 → busy_o=1, count_o 5,4,3,2,1,0; done_o high exactly one cycle, 5 cycles after the load edge; busy_o=0 afterwards.
- Periodic: load 3, periodic_i=1 → done_o high every 3rd cycle for ≥4 periods; count_o sequence 3,2,1,3,2,1; busy_o stays 1. cancel_i → IDLE, count_o=0, no further pulses.
- Hold: load 4, hold_i high 3 cycles when count_o=2 → count_o frozen at 2; done_o delayed exactly 3 cycles (7 cycles after load). Hold on the terminal edge (count_o=1) → no pulse until released.
- Retrigger and collision: load 4, reload with 6 while count_o=2 → count restarts at 6, no done until 6 cycles later. Load 2 asserted on the terminal edge of a running timer → no done that cycle.
- Zero and maximum values: load 0 → done_o=1 next cycle, busy_o=0. WIDTH_P=8, load 255 → done_o after exactly 255 cycles, no wrap.
- Reset and cancel priority: reset_i mid-RUN at count_o=3 → next cycle count_o=0, busy_o=0, done_o=0. cancel_i and load_i together → IDLE, no load. N=1 periodic → done_o continuously high.
